// File: rtl/pc_gen_if.sv
// Fetch-PC control bundle between the hazard/stall/branch logic (master)
// and the PC generator (slave).
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            pc_write_i;
    logic            mem_stall_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            jump_valid_i;
    logic [XLEN-1:0] jump_pc_i;
    logic            call_i;
    logic            ret_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            ras_empty_o;

    modport master (
        output start_i, pc_write_i, mem_stall_i, redirect_valid_i, redirect_pc_i,
        output jump_valid_i, jump_pc_i, call_i, ret_i,
        input  pc_o, pc_valid_o, ras_empty_o
    );

    modport slave (
        input  start_i, pc_write_i, mem_stall_i, redirect_valid_i, redirect_pc_i,
        input  jump_valid_i, jump_pc_i, call_i, ret_i,
        output pc_o, pc_valid_o, ras_empty_o
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: next-PC selection across redirects,
// return-address-stack predictions, jumps and sequential fetch, with a start/idle sequencer.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    pc_gen_if.slave  bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_inc;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [PW-1:0]   top_q, top_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic            push;
    logic            redirect_adv, seq_adv;
    logic            pc_valid;

    assign pc_inc       = pc_q + XLEN'(INC);
    assign redirect_adv = ~bus.mem_stall_i;
    assign seq_adv      = bus.pc_write_i & ~bus.mem_stall_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i)  state_d = RUN;
            RUN:     if (!bus.start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_valid = (state_q == RUN);
    end

    // Next-PC selection; leaving RUN (or sitting idle) flushes RAS and pending redirect.
    always_comb begin
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        top_d        = top_q;
        cnt_d        = cnt_q;
        push         = 1'b0;
        if (state_q != RUN || !bus.start_i) begin
            pc_d         = RESET_VEC;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
            top_d        = '1;
        end else begin
            if (bus.mem_stall_i && bus.redirect_valid_i) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = bus.redirect_pc_i;
            end
            if (redirect_adv && (bus.redirect_valid_i || pend_valid_q)) begin
                pc_d         = bus.redirect_valid_i ? bus.redirect_pc_i : pend_pc_q;
                pend_valid_d = 1'b0;
            end else if (seq_adv) begin
                if (bus.ret_i && cnt_q != '0) begin
                    pc_d  = ras_q[top_q];
                    top_d = top_q - PW'(1);
                    cnt_d = cnt_q - CW'(1);
                end else if (bus.jump_valid_i) begin
                    pc_d = bus.jump_pc_i;
                    if (bus.call_i) begin
                        push  = 1'b1;
                        top_d = top_q + PW'(1);
                        // A full stack overwrites its oldest slot, which is the one top_d lands on.
                        if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    pc_d = pc_inc;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q         <= RESET_VEC;
            pend_valid_q <= 1'b0;
            top_q        <= '1;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            top_q        <= top_d;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        pend_pc_q <= pend_pc_d;
        if (push) ras_q[top_d] <= pc_inc;
    end

    assign bus.pc_o        = pc_q;
    assign bus.pc_valid_o  = pc_valid;
    assign bus.ras_empty_o = (cnt_q == '0);
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: queue-based reference model checked every cycle, plus
// directed vectors with literal expectations, and an 8-bit instance for wrap.
module tb_pc_gen;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    pc_gen_if #(.XLEN(32)) ba ();
    pc_gen_if #(.XLEN(8))  bb ();

    pc_gen #(.XLEN(32), .RESET_VEC(32'h0), .INC(4), .RAS_DEPTH(4)) u_a (
        .clk_i(clk_i), .rst_i(rst_i), .bus(ba));
    pc_gen #(.XLEN(8), .RESET_VEC(8'h0), .INC(4), .RAS_DEPTH(4)) u_b (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bb));

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model for the 32-bit instance: RAS is a plain queue, newest at the back.
    bit          m_run = 1'b0;
    logic [31:0] m_pc = 32'h0;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    logic [31:0] m_ras [$];

    initial forever begin
        @(posedge clk_i or posedge rst_i);
        if (rst_i) begin
            m_run = 0; m_pc = 0; m_pend = 0; m_ras.delete();
        end else if (!m_run) begin
            m_pc = 0;
            if (ba.start_i) m_run = 1;
        end else if (!ba.start_i) begin
            m_run = 0; m_pc = 0; m_pend = 0; m_ras.delete();
        end else if (ba.mem_stall_i) begin
            if (ba.redirect_valid_i) begin
                m_pend = 1; m_pend_pc = ba.redirect_pc_i;
            end
        end else if (ba.redirect_valid_i || m_pend) begin
            m_pc   = ba.redirect_valid_i ? ba.redirect_pc_i : m_pend_pc;
            m_pend = 0;
        end else if (ba.pc_write_i) begin
            if (ba.ret_i && m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else if (ba.jump_valid_i) begin
                if (ba.call_i) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                end
                m_pc = ba.jump_pc_i;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    initial forever begin
        @(negedge clk_i);
        chk("model{pc,valid,empty}", {30'h0, ba.pc_o, ba.pc_valid_o, ba.ras_empty_o},
            {30'h0, m_pc, m_run, (m_ras.size() == 0)});
    end

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic expect_a(input string name, input logic [31:0] pc, input logic vld, input logic emp);
        chk({name, ".pc"}, 64'(ba.pc_o), 64'(pc));
        chk({name, ".valid"}, 64'(ba.pc_valid_o), 64'(vld));
        chk({name, ".empty"}, 64'(ba.ras_empty_o), 64'(emp));
    endtask

    task automatic clear_ctl();
        ba.redirect_valid_i = 0; ba.jump_valid_i = 0; ba.call_i = 0; ba.ret_i = 0;
    endtask

    initial begin
        ba.start_i = 0; ba.pc_write_i = 1; ba.mem_stall_i = 0;
        ba.redirect_pc_i = 0; ba.jump_pc_i = 0; clear_ctl();
        bb.start_i = 0; bb.pc_write_i = 1; bb.mem_stall_i = 0; bb.redirect_valid_i = 0;
        bb.redirect_pc_i = 0; bb.jump_valid_i = 0; bb.jump_pc_i = 0; bb.call_i = 0; bb.ret_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        expect_a("reset", 32'h0, 0, 1);
        rst_i = 0;

        // Start: idle value, then sequential fetch.
        ba.start_i = 1;
        tick(); expect_a("start0", 32'h0, 1, 1);
        tick(); expect_a("seq4", 32'h4, 1, 1);
        tick(); expect_a("seq8", 32'h8, 1, 1);
        tick(); expect_a("seqC", 32'hC, 1, 1);
        tick(); expect_a("seq10", 32'h10, 1, 1);

        // Load-use stall holds for three cycles.
        ba.pc_write_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_a("hold", 32'h10, 1, 1);
        end
        ba.pc_write_i = 1;
        tick(); expect_a("release", 32'h14, 1, 1);

        // Redirect pulsed in the middle of a 4-cycle memory stall.
        ba.mem_stall_i = 1;
        for (int i = 0; i < 4; i++) begin
            ba.redirect_valid_i = (i == 1); ba.redirect_pc_i = 32'h200;
            tick(); expect_a("memstall", 32'h14, 1, 1);
        end
        ba.redirect_valid_i = 0; ba.mem_stall_i = 0;
        tick(); expect_a("pend_apply", 32'h200, 1, 1);
        tick(); expect_a("pend_next", 32'h204, 1, 1);

        // Call then return.
        ba.jump_valid_i = 1; ba.jump_pc_i = 32'h40;
        tick(); expect_a("jump40", 32'h40, 1, 1);
        ba.call_i = 1; ba.jump_pc_i = 32'h100;
        tick(); expect_a("call", 32'h100, 1, 0);
        clear_ctl(); ba.ret_i = 1;
        tick(); expect_a("ret", 32'h44, 1, 1);
        clear_ctl();

        // Restart to a clean RAS, then overflow it with five calls.
        ba.start_i = 0;
        tick(); expect_a("stop", 32'h0, 0, 1);
        ba.start_i = 1;
        tick(); expect_a("restart", 32'h0, 1, 1);
        ba.jump_valid_i = 1; ba.call_i = 1;
        for (int i = 0; i < 5; i++) begin
            ba.jump_pc_i = (i == 4) ? 32'h100 : 32'((i + 1) * 16);
            tick();
        end
        expect_a("ovf_calls", 32'h100, 1, 0);
        clear_ctl(); ba.ret_i = 1;
        tick(); expect_a("pop1", 32'h44, 1, 0);
        tick(); expect_a("pop2", 32'h34, 1, 0);
        tick(); expect_a("pop3", 32'h24, 1, 0);
        tick(); expect_a("pop4", 32'h14, 1, 1);
        tick(); expect_a("pop_empty", 32'h18, 1, 1);
        clear_ctl();

        // Redirect beats ret and call; RAS left untouched.
        ba.jump_valid_i = 1; ba.call_i = 1; ba.jump_pc_i = 32'h300;
        tick(); expect_a("call300", 32'h300, 1, 0);
        ba.redirect_valid_i = 1; ba.redirect_pc_i = 32'h500;
        ba.ret_i = 1; ba.jump_pc_i = 32'h600;
        tick(); expect_a("prio", 32'h500, 1, 0);
        clear_ctl(); ba.ret_i = 1;
        tick(); expect_a("ras_kept", 32'h1C, 1, 1);
        clear_ctl();

        // Redirect overrides a load-use stall.
        ba.pc_write_i = 0; ba.redirect_valid_i = 1; ba.redirect_pc_i = 32'h700;
        tick(); expect_a("redir_loaduse", 32'h700, 1, 1);
        clear_ctl(); ba.pc_write_i = 1;

        // Async reset while a redirect is pending discards it.
        ba.mem_stall_i = 1; ba.redirect_valid_i = 1; ba.redirect_pc_i = 32'h800;
        tick(); expect_a("pend_hold", 32'h700, 1, 1);
        ba.redirect_valid_i = 0;
        #1 rst_i = 1;
        #1 expect_a("async_rst", 32'h0, 0, 1);
        @(negedge clk_i);
        rst_i = 0; ba.mem_stall_i = 0;
        tick(); expect_a("post_rst0", 32'h0, 1, 1);
        tick(); expect_a("post_rst4", 32'h4, 1, 1);

        // 8-bit instance: increment wraps silently.
        bb.start_i = 1;
        tick(); chk("b.start", 64'(bb.pc_o), 64'h00);
        bb.jump_valid_i = 1; bb.jump_pc_i = 8'hFC;
        tick(); chk("b.jumpFC", 64'(bb.pc_o), 64'hFC);
        bb.jump_valid_i = 0;
        tick(); chk("b.wrap", 64'(bb.pc_o), 64'h00);
        chk("b.valid", 64'(bb.pc_valid_o), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
